irq_ctrl: RTL and testbench

Multi-channel interrupt controller for the sigma core: a parametrised successor to the single-button interrupt adapter. It accepts NUM_IRQ interrupt lines and handles each one as edge- or level-sensitive with a per-channel enable. Pending interrupts are latched and arbitrated by fixed priority. One request at a time is presented to the core on the irq_req_o / irq_code_bo / irq_ack_i handshake.

---
 rtl/irq_ctrl_if.sv | 21 ++
 rtl/irq_ctrl.sv | 132 +++++++++++++
 tb/tb_irq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - request/code/acknowledge handshake between irq_ctrl and the core
interface irq_ctrl_if #(
    parameter int CODE_W = 8
) ();
    logic              irq_req_o;
    logic [CODE_W-1:0] irq_code_bo;
    logic              irq_ack_i;

    // the interrupt controller drives request and code, the core answers with ack
    modport master (
        output irq_req_o,
        output irq_code_bo,
        input  irq_ack_i
    );

    modport slave (
        input  irq_req_o,
        input  irq_code_bo,
        output irq_ack_i
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - multi-channel edge/level interrupt controller, fixed priority, optional input sync (IRQ_CTRL_SYNC_EN)
module irq_ctrl #(
    parameter int NUM_IRQ   = 8,
    parameter int CODE_W    = 8,
    parameter int CODE_BASE = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_edge_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    irq_ctrl_if.master         core_if,
    output logic [NUM_IRQ-1:0] irq_pending_bo
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] irq_event;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               ack_accept;
    logic               req_q, req_d;
    logic [CODE_W-1:0]  code_q, code_d;
    state_t             state_q, state_d;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;

    // two-stage synchroniser feeding the detector
    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
    end

    // synchroniser flops, cleared so a line high at release still looks like a rising edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    // event detection, pending update (set beats clear) and lowest-index arbitration
    always_comb begin
        irq_prev_d = irq_s;
        irq_event  = (irq_edge_i & irq_s & ~irq_prev_q) | (~irq_edge_i & irq_s);
        eligible   = pend_q & irq_en_i;
        ack_accept = (state_q == S_REQ) && core_if.irq_ack_i;
        clr_mask   = ack_accept ? (NUM_IRQ'(1) << sel_q) : '0;
        pend_d     = (pend_q & ~clr_mask) | (irq_event & irq_en_i);
        win_valid  = 1'b0;
        win_idx    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // request FSM: latch a winner in IDLE, hold it untouched until the core acks
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_REQ;
                    sel_d   = win_idx;
                    req_d   = 1'b1;
                    code_d  = CODE_W'(CODE_BASE) + CODE_W'(win_idx);
                end
            end
            S_REQ: begin
                if (core_if.irq_ack_i) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    code_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                code_d  = '0;
            end
        endcase
    end

    // state, pending and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            pend_q     <= '0;
            sel_q      <= '0;
            req_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            code_q     <= code_d;
        end
    end

    assign core_if.irq_req_o   = req_q;
    assign core_if.irq_code_bo = code_q;
    assign irq_pending_bo      = pend_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed check of irq_ctrl against a behavioural model
module tb_irq_ctrl;
    localparam int N  = 8;
    localparam int CW = 8;
    localparam int CB = 3;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [N-1:0] irq_i;
    logic [N-1:0] irq_edge_i;
    logic [N-1:0] irq_en_i;
    logic [N-1:0] irq_pending_bo;

    int n_total = 0;
    int n_bad   = 0;

    bit m_pend [N];
    bit m_prev [N];
    bit m_s1   [N];
    bit m_s2   [N];
    bit m_busy;
    int m_sel;

    irq_ctrl_if #(.CODE_W(CW)) core_if ();

    irq_ctrl #(.NUM_IRQ(N), .CODE_W(CW), .CODE_BASE(CB)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .irq_i          (irq_i),
        .irq_edge_i     (irq_edge_i),
        .irq_en_i       (irq_en_i),
        .core_if        (core_if),
        .irq_pending_bo (irq_pending_bo)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_pend();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_busy = 0;
        m_sel  = 0;
    endtask

    // one clock edge of the controller's rules, applied to the inputs present at that edge
    task automatic model_edge(input logic [N-1:0] irq, input logic [N-1:0] edg,
                              input logic [N-1:0] en, input logic ack);
        bit s  [N];
        bit ev [N];
        int win;
        int clr;
        for (int i = 0; i < N; i++) begin
`ifdef IRQ_CTRL_SYNC_EN
            s[i]    = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = irq[i];
`else
            s[i] = irq[i];
`endif
            ev[i] = edg[i] ? (s[i] && !m_prev[i]) : s[i];
        end
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && m_pend[i] && en[i]) win = i;
        clr = -1;
        if (m_busy) begin
            if (ack) begin
                clr    = m_sel;
                m_busy = 0;
            end
        end else if (win >= 0) begin
            m_busy = 1;
            m_sel  = win;
        end
        for (int i = 0; i < N; i++) begin
            if (i == clr) m_pend[i] = 0;
            if (ev[i] && en[i]) m_pend[i] = 1;
            m_prev[i] = s[i];
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_req"}, 32'(core_if.irq_req_o), 32'(m_busy));
        check({tag, "_code"}, 32'(core_if.irq_code_bo), m_busy ? 32'(CB + m_sel) : 32'd0);
        check({tag, "_pend"}, 32'(irq_pending_bo), 32'(model_pend()));
    endtask

    // drive at the falling edge, clock once, compare at the next falling edge
    task automatic step(input logic [N-1:0] irq, input logic [N-1:0] edg,
                        input logic [N-1:0] en, input logic ack, input string tag);
        irq_i             = irq;
        irq_edge_i        = edg;
        irq_en_i          = en;
        core_if.irq_ack_i = ack;
        @(posedge clk_i);
        model_edge(irq, edg, en, ack);
        @(negedge clk_i);
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_req", 32'(core_if.irq_req_o), 32'd0);
        check("rst_code", 32'(core_if.irq_code_bo), 32'd0);
        check("rst_pend", 32'(irq_pending_bo), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r_irq, r_edge, r_en;
        logic         r_ack;
        irq_i             = '0;
        irq_edge_i        = '1;
        irq_en_i          = '1;
        core_if.irq_ack_i = 1'b0;
        rst_n_i           = 1'b1;
        @(negedge clk_i);
        do_reset();

        // edge pulse on ch2
        step(8'h04, 8'hFF, 8'hFF, 1'b0, "e2a");
        step(8'h00, 8'hFF, 8'hFF, 1'b0, "e2b");
`ifndef IRQ_CTRL_SYNC_EN
        check("e2_code5", 32'(core_if.irq_code_bo), 32'd5);
`endif
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "e2w");
        step(8'h00, 8'hFF, 8'hFF, 1'b1, "e2ack");
        step(8'h00, 8'hFF, 8'hFF, 1'b0, "e2idle");

        // simultaneous ch1 and ch6
        step(8'h42, 8'hFF, 8'hFF, 1'b0, "p16a");
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "p16w");
`ifndef IRQ_CTRL_SYNC_EN
        check("p16_code4", 32'(core_if.irq_code_bo), 32'd4);
`endif
        step(8'h00, 8'hFF, 8'hFF, 1'b1, "p16ack1");
        step(8'h00, 8'hFF, 8'hFF, 1'b0, "p16next");
`ifndef IRQ_CTRL_SYNC_EN
        check("p16_code9", 32'(core_if.irq_code_bo), 32'd9);
`endif
        step(8'h00, 8'hFF, 8'hFF, 1'b1, "p16ack2");
        step(8'h00, 8'hFF, 8'hFF, 1'b0, "p16end");

        // level ch0 held across ack, then deasserted
        for (int i = 0; i < 4; i++) step(8'h01, 8'hFE, 8'hFF, 1'b0, "lvl");
        step(8'h01, 8'hFE, 8'hFF, 1'b1, "lvlack");
        for (int i = 0; i < 2; i++) step(8'h01, 8'hFE, 8'hFF, 1'b0, "lvlre");
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFE, 8'hFF, 1'b0, "lvloff");
        step(8'h00, 8'hFE, 8'hFF, 1'b1, "lvlack2");
        for (int i = 0; i < 4; i++) step(8'h00, 8'hFE, 8'hFF, 1'b0, "lvlquiet");
        check("lvl_done", 32'(core_if.irq_req_o), 32'd0);

        // masking: disabled pulse is dropped, pending-but-disabled waits for enable
        step(8'h08, 8'hFF, 8'hF7, 1'b0, "mask");
        for (int i = 0; i < 4; i++) step(8'h00, 8'hFF, 8'hF7, 1'b0, "maskw");
        step(8'h08, 8'hFF, 8'hFF, 1'b0, "m3set");
        step(8'h00, 8'hFF, 8'hF7, 1'b0, "m3off");
        for (int i = 0; i < 4; i++) step(8'h00, 8'hFF, 8'hF7, 1'b0, "m3hold");
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "m3on");
        step(8'h00, 8'hFF, 8'hFF, 1'b1, "m3ack");

        // ack coinciding with a new edge on the served channel; ack while idle
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b1, "idleack");
        step(8'h10, 8'hFF, 8'hFF, 1'b0, "co_a");
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "co_w");
        step(8'h10, 8'hFF, 8'hFF, 1'b1, "co_ack");
        for (int i = 0; i < 4; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "co_re");
        step(8'h00, 8'hFF, 8'hFF, 1'b1, "co_ack2");

        // asynchronous reset in the middle of a request, between edges
        step(8'h04, 8'hFF, 8'hFF, 1'b0, "ar_a");
        for (int i = 0; i < 3; i++) step(8'h00, 8'hFF, 8'hFF, 1'b0, "ar_w");
        #2;
        do_reset();

        // random traffic with occasional resets
        r_edge = 8'($urandom);
        r_en   = 8'hFF;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) r_edge = 8'($urandom);
            if ($urandom_range(0, 15) == 0) r_en = 8'($urandom | $urandom);
            r_irq = 8'($urandom & $urandom & $urandom);
            r_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(r_irq, r_edge, r_en, r_ack, "rnd");
            if (c % 700 == 699) begin
                #2;
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
